// File: rtl/sub_bytes_engine.sv
// rtl/sub_bytes_engine.sv - AES SubBytes engine, LANES S-box lookups per cycle over a 128-bit state
// Optional macro SUBBYTES_INV_EN compiles in the inverse S-box and honours in_inv.
module sub_bytes_engine #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int NCHUNK = 16 / LANES;
  localparam logic [3:0] LAST = 4'(NCHUNK - 1);
  localparam bit LANES_OK = (LANES == 1) || (LANES == 2) || (LANES == 4) ||
                            (LANES == 8) || (LANES == 16);

  generate
    if (!LANES_OK) begin : g_bad_lanes
      $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, LOOKUP, DRAIN, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [127:0] data_q;
  logic [7:0]  st_byte  [16];
  logic [7:0]  res      [16];
  logic [7:0]  lane_byte[LANES];
  logic [7:0]  sbox_q   [LANES];
  logic [3:0]  wr_chunk;
  logic        wr_en;

`ifdef SUBBYTES_INV_EN
  logic        inv_q;
`else
  logic        unused_in_inv;
  assign unused_in_inv = in_inv;
`endif

  // S-box computed as GF(2^8) inverse (x^254) followed by the AES affine map.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

`ifdef SUBBYTES_INV_EN
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] t;
    t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction
`endif

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = LOOKUP;
      end
      LOOKUP: if (cnt == LAST) state_nxt = DRAIN;
      DRAIN:  state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    for (int b = 0; b < 16; b++) st_byte[b] = data_q[127 - 8*b -: 8];
    for (int l = 0; l < LANES; l++) lane_byte[l] = st_byte[4'(int'(cnt) * LANES + l)];
  end

  // The S-box register lags the counter by one cycle, so results land one chunk behind.
  assign wr_en    = ((state == LOOKUP) && (cnt != 4'd0)) || (state == DRAIN);
  assign wr_chunk = (state == DRAIN) ? cnt : cnt - 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      data_q <= '0;
`ifdef SUBBYTES_INV_EN
      inv_q  <= 1'b0;
`endif
      for (int b = 0; b < 16; b++) res[b] <= 8'h00;
      for (int l = 0; l < LANES; l++) sbox_q[l] <= 8'h00;
    end else begin
      state <= state_nxt;
      if (in_valid && in_ready) begin
        data_q <= in_data;
        cnt    <= 4'd0;
`ifdef SUBBYTES_INV_EN
        inv_q  <= in_inv;
`endif
      end else if ((state == LOOKUP) && (cnt != LAST)) begin
        cnt <= cnt + 4'd1;
      end
      for (int l = 0; l < LANES; l++) begin
`ifdef SUBBYTES_INV_EN
        sbox_q[l] <= inv_q ? inv_sbox(lane_byte[l]) : fwd_sbox(lane_byte[l]);
`else
        sbox_q[l] <= fwd_sbox(lane_byte[l]);
`endif
      end
      if (wr_en) begin
        for (int l = 0; l < LANES; l++) res[4'(int'(wr_chunk) * LANES + l)] <= sbox_q[l];
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int b = 0; b < 16; b++) out_data[127 - 8*b -: 8] = res[b];
  end

endmodule
